// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
//   Synchronous instruction memory for the RISC-V core / fetch driver.
//   An internal program counter steps through the memory. Each next_instr
//   request registers the next sequential word. A separate write port loads
//   the program image at any time.
//
//   Parameters
//     BUS    MSB index of an instruction word (word width = BUS+1)
//     DEPTH  number of instruction words (power of two, >= 2)
//     NOP    word driven when no valid instruction is held
//
//   Ports
//     clk          clock, all logic on the rising edge
//     rst_n        asynchronous active-low reset (released synchronously
//                  by the surrounding reset logic)
//     next_instr   request the next instruction
//     instruction  registered instruction word
//     instr_valid  instruction holds a word fetched from memory
//     pc           word address of the next fetch
//     done         every word has been fetched (sticky until reset)
//     wr_en        program-load write strobe
//     wr_addr      program-load word address
//     wr_data      program-load data
//
//   Configuration macro
//     INSTR_MEM_WRAP_EN  When defined, the program loops forever: pc wraps
//                        to 0 after the last word and done stays 0.
//                        When undefined (default), done becomes sticky
//                        after the last word, and later requests return NOP.
// -----------------------------------------------------------------------------
module instr_mem #(
   parameter int             BUS   = 31,
   parameter int             DEPTH = 256,
   parameter logic [BUS:0]   NOP   = 32'h0000_0013,
   localparam int            AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          next_instr,
   output logic [BUS:0]  instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          done,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [BUS:0]  wr_data
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [BUS:0]  mem_reg [DEPTH];
   logic [BUS:0]  instruction_reg;
   logic          instr_valid_reg;
   logic [AW-1:0] pc_reg;
   logic          done_reg;
   logic          done_set;

   // The memory has no reset, so the program image survives a core reset.
   // Writes that arrive while reset is asserted are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

`ifdef INSTR_MEM_WRAP_EN
   // Free-running loop: the program never completes.
   assign done_set = 1'b0;
`else
   // Fetching the last word completes the program on the same edge.
   assign done_set = (pc_reg == LAST_ADDR);
`endif

   // The fetch reads mem_reg on the same edge as any write. Because of
   // non-blocking semantics, a write to the word being fetched is seen
   // only by a later fetch (read-before-write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction_reg <= NOP;
         instr_valid_reg <= 1'b0;
         pc_reg          <= '0;
         done_reg        <= 1'b0;
      end else if (next_instr) begin
         if (!done_reg) begin
            instruction_reg <= mem_reg[pc_reg];
            instr_valid_reg <= 1'b1;
            pc_reg          <= pc_reg + 1'b1;   // wraps to 0 after LAST_ADDR
            done_reg        <= done_set;
         end else begin
            // A request after completion gets NOP; pc remains parked at 0.
            instruction_reg <= NOP;
            instr_valid_reg <= 1'b0;
         end
      end
   end

   assign instruction = instruction_reg;
   assign instr_valid = instr_valid_reg;
   assign pc          = pc_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_instr_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_mem
//   Directed testbench for instr_mem (DEPTH = 8). It covers the following:
//     - reset values
//     - program load and sequential fetch
//     - hold behaviour when no request is made
//     - read-before-write on a same-address write
//     - asynchronous reset in the middle of a run, including a dropped write
//     - completion (done) and post-done NOP behaviour
// -----------------------------------------------------------------------------
module tb_instr_mem;

   localparam int BUS   = 31;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          next_instr;
   logic [BUS:0]  instruction;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          done;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [BUS:0]  wr_data;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] prog [8];

   instr_mem #(.BUS(BUS), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_instr  (next_instr),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .done        (done),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_instr,
                              input logic e_valid, input logic [2:0] e_pc, input logic e_done);
      check({tag, ".instruction"}, instruction, e_instr);
      check({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
      check({tag, ".pc"}, {29'd0, pc}, {29'd0, e_pc});
      check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
      $display("%0t %s: instr=%h valid=%0b pc=%0d done=%0b", $time, tag,
               instruction, instr_valid, pc, done);
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      prog[0] = 32'h0050_0093; prog[1] = 32'h00a0_0113;
      prog[2] = 32'h0020_81b3; prog[3] = 32'h0000_0013;
      prog[4] = 32'h0010_0193; prog[5] = 32'h0020_0213;
      prog[6] = 32'h0030_0293; prog[7] = 32'h0040_0313;

      // Reset with a request pending; the outputs must stay at reset values.
      rst_n = 1'b0; next_instr = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      #2;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state($sformatf("reset_hold%0d", i), NOP, 1'b0, 3'd0, 1'b0);
      end
      next_instr = 1'b0;
      rst_n = 1'b1;

      // Load the program image.
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = prog[i];
         tick();
      end
      wr_en = 1'b0;
      check_state("after_load", NOP, 1'b0, 3'd0, 1'b0);

      // First two fetches.
      next_instr = 1'b1;
      tick(); check_state("fetch0", prog[0], 1'b1, 3'd1, 1'b0);
      tick(); check_state("fetch1", prog[1], 1'b1, 3'd2, 1'b0);

      // No request for 5 cycles: everything holds.
      next_instr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_state($sformatf("idle%0d", i), 32'h00a0_0113, 1'b1, 3'd2, 1'b0);
      end

      // Fetch at pc=2 while writing mem[2]: old data is returned.
      next_instr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hdead_beef;
      tick();
      wr_en = 1'b0;
      check_state("fetch2_rbw", 32'h0020_81b3, 1'b1, 3'd3, 1'b0);

      // Asynchronous reset between edges at pc=3, plus a write that must be dropped.
      next_instr = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'hbad0_bad0;
      rst_n = 1'b0;
      #1;
      check_state("async_rst", NOP, 1'b0, 3'd0, 1'b0);
      tick();
      check_state("rst_edge", NOP, 1'b0, 3'd0, 1'b0);
      wr_en = 1'b0;
      rst_n = 1'b1;

      // Rerun from the start; memory is retained and mem[2] now holds the new word.
      next_instr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] e;
         e = (i == 2) ? 32'hdead_beef : prog[i];
         tick();
         check_state($sformatf("rerun%0d", i), e, 1'b1, 3'((i + 1) % 8),
                     (i == 7) ? 1'b1 : 1'b0);
      end

      // Request after the last word.
      tick();
`ifdef INSTR_MEM_WRAP_EN
      check_state("post_last", prog[0], 1'b1, 3'd1, 1'b0);
`else
      check_state("post_done", NOP, 1'b0, 3'd0, 1'b1);
      tick();
      check_state("post_done2", NOP, 1'b0, 3'd0, 1'b1);
      next_instr = 1'b0;
      tick();
      check_state("done_idle", NOP, 1'b0, 3'd0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
